minterm_sweeper: RTL

//  Upstream stimulus/capture stage for the 4-input combinational function blocks (decoder4x16 family).
//  On start, drives every input combination 0..2^WIDTH-1 onto x, one per cycle, and samples the

---
 rtl/minterm_sweeper_pkg.sv | 17 +
 rtl/minterm_sweeper_counter.sv | 24 ++
 rtl/minterm_sweeper.sv | 107 ++++++++++
 3 files changed

// File: rtl/minterm_sweeper_pkg.sv
// Shared state encoding, reference truth table and sweep-length helper for minterm_sweeper.
package minterm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Truth table of the 4-input prime detector: minterms 2,3,5,7,11,13.
  localparam logic [15:0] PRIME4_TABLE = 16'h28AC;

  function automatic int sweep_len(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/minterm_sweeper_counter.sv
// Index counter for the sweep: synchronous clear, count enable, terminal count at all-ones.
module sweep_counter
  import minterm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Incrementing past N-1 wraps to 0, which is exactly the x value wanted in DONE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + WIDTH'(1);
  end

  assign tc = &count;

endmodule

// File: rtl/minterm_sweeper.sv
// Drives every input combination of a combinational block and captures its truth table and minterm count.
// Optional MINTERM_SWEEP_CHECK_EN adds a mismatch flag comparing the captured table against EXPECTED.
//
// state    | meaning
// ST_IDLE  | waiting for start, x=0
// ST_SWEEP | one sample per unpaused cycle, x = current minterm
// ST_DONE  | one-cycle done pulse, results stable
module minterm_sweeper
  import minterm_pkg::*;
#(
  parameter int WIDTH = 4
`ifdef MINTERM_SWEEP_CHECK_EN
  ,
  parameter logic [2**WIDTH-1:0] EXPECTED = PRIME4_TABLE
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  f_in,
  output logic [WIDTH-1:0]      x,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   table_o,
  output logic [WIDTH:0]        ones
`ifdef MINTERM_SWEEP_CHECK_EN
  ,
  output logic                  mismatch
`endif
);

  localparam int N = sweep_len(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] idx;
  logic             tc;
  logic             take;
  logic             clear;
  logic [N-1:0]     table_nxt;

  assign take  = (state == ST_SWEEP) && !pause;
  assign clear = (state == ST_IDLE) && start;

  sweep_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (take),
    .count (idx),
    .tc    (tc)
  );

  assign x     = idx;
  assign valid = take;

  always_comb begin
    table_nxt      = table_o;
    table_nxt[idx] = f_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      table_o  <= '0;
      ones     <= '0;
`ifdef MINTERM_SWEEP_CHECK_EN
      mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SWEEP;
            busy     <= 1'b1;
            table_o  <= '0;
            ones     <= '0;
`ifdef MINTERM_SWEEP_CHECK_EN
            mismatch <= 1'b0;
`endif
          end
        end
        ST_SWEEP: begin
          if (take) begin
            table_o <= table_nxt;
            ones    <= ones + {{WIDTH{1'b0}}, f_in};
            if (tc) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
`ifdef MINTERM_SWEEP_CHECK_EN
              mismatch <= (table_nxt != EXPECTED);
`endif
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
